// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    localparam int unsigned CH_DASH  = 16;
    localparam int unsigned CH_UNDER = 17;
    localparam int unsigned CH_H     = 18;
    localparam int unsigned CH_L     = 19;
    localparam int unsigned CH_P     = 20;
    localparam int unsigned CH_R     = 21;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_UNDER = 7'h08;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_OFF   = 7'h00;

endpackage

// File: rtl/display_char_decoder.sv
// Combinational character-code to active-high 7-segment decoder.
module display_char_decoder
    import display_pkg::*;
#(
    parameter int CHAR_LEN = 6
) (
    input  logic [CHAR_LEN-1:0] code,
    output logic [6:0]          seg
);

    logic [31:0] code_w;

    always_comb begin
        code_w = 32'(code);
        seg    = SEG_OFF;
        if (code_w < 32'd16) begin
            seg = SEG_HEX[code_w[3:0]];
        end else begin
            case (code_w)
                CH_DASH:  seg = SEG_DASH;
                CH_UNDER: seg = SEG_UNDER;
                CH_H:     seg = SEG_H;
                CH_L:     seg = SEG_L;
                CH_P:     seg = SEG_P;
                CH_R:     seg = SEG_R;
                default:  seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller with per-slot blanking gap and frame snapshots.
// Optional brightness control is enabled by defining DISPLAY_SCAN_DIM_EN.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int LEN        = 4,
    parameter int CHAR_LEN   = 6,
    parameter int DIV        = 12500,
    parameter int BLANK      = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      csi_clk,
    input  logic                      rsi_reset_n,
    input  logic [LEN*CHAR_LEN-1:0]   numbers,
    input  logic [LEN-1:0]            dots,
    input  logic                      ena,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [2:0]                dim,
`endif
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [LEN-1:0]            digit_sel,
    output logic                      frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0]  CNT_BLANK_END = CW'(BLANK - 1);
    localparam logic [CW-1:0]  CNT_LAST      = CW'(DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST      = IW'(LEN - 1);
    localparam logic [6:0]     POL_SEG       = {7{ACTIVE_LOW != 0}};
    localparam logic           POL_DP        = (ACTIVE_LOW != 0);
    localparam logic [LEN-1:0] POL_SEL       = {LEN{ACTIVE_LOW != 0}};

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [LEN*CHAR_LEN-1:0] snap_num_q, snap_num_d;
    logic [LEN-1:0]          snap_dots_q, snap_dots_d;
    logic                    fs_d;
    logic                    sel_gate;
    logic [CHAR_LEN-1:0]     code_cur;
    logic [6:0]              seg_dec, seg_raw;
    logic                    dp_raw;
    logic [LEN-1:0]          sel_raw;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_num_d  = snap_num_q;
        snap_dots_d = snap_dots_q;
        fs_d        = 1'b0;
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_num_d  = numbers;
                    snap_dots_d = dots;
                    idx_d       = '0;
                    cnt_d       = '0;
                    fs_d        = 1'b1;
                    state_d     = ST_BLANK;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BLANK_END) state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            snap_num_d  = numbers;
                            snap_dots_d = dots;
                            fs_d        = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0] dim_q, dim_d, dim_cnt_q, dim_cnt_d;

    always_comb begin
        dim_d     = fs_d ? dim : dim_q;
        dim_cnt_d = (state_q == ST_SHOW && state_d == ST_SHOW) ? dim_cnt_q + 3'd1 : 3'd0;
        sel_gate  = (dim_cnt_d <= dim_d);
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            dim_q     <= '0;
            dim_cnt_q <= '0;
        end else begin
            dim_q     <= dim_d;
            dim_cnt_q <= dim_cnt_d;
        end
    end
`else
    assign sel_gate = 1'b1;
`endif

    // Pins are built from next-state values so they line up with the state register.
    assign code_cur = snap_num_d[idx_d*CHAR_LEN +: CHAR_LEN];

    display_char_decoder #(.CHAR_LEN(CHAR_LEN)) u_dec (
        .code (code_cur),
        .seg  (seg_dec)
    );

    always_comb begin
        seg_raw = '0;
        dp_raw  = 1'b0;
        sel_raw = '0;
        if (state_d == ST_SHOW) begin
            seg_raw = seg_dec;
            dp_raw  = snap_dots_d[idx_d];
            if (sel_gate) sel_raw[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_num_q  <= '0;
            snap_dots_q <= '0;
            frame_start <= 1'b0;
            seg         <= POL_SEG;
            dp          <= POL_DP;
            digit_sel   <= POL_SEL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_num_q  <= snap_num_d;
            snap_dots_q <= snap_dots_d;
            frame_start <= fs_d;
            seg         <= seg_raw ^ POL_SEG;
            dp          <= dp_raw ^ POL_DP;
            digit_sel   <= sel_raw ^ POL_SEL;
        end
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Consumes the character codes, dot flags and enable held by the display register file.
- Sequences one digit at a time with an anti-ghosting blanking gap, then decodes each code to segments.
- Snapshots inputs at frame boundaries so a frame never tears; sits between the Avalon register block and the board pins.

Parameters:
- LEN, 4, number of digits scanned.
- CHAR_LEN, 6, width of one character code.
- DIV, 12500, clock cycles per digit slot; legal when DIV > BLANK.
- BLANK, 64, cycles at the start of each slot with all outputs off; legal when BLANK >= 1.
- ACTIVE_LOW, 1, when 1 seg/dp/digit_sel are driven active-low; when 0 they are driven active-high.

Ports:
- csi_clk  in  1  sole clock.
- rsi_reset_n  in  1  reset, asynchronous, active-low.
- numbers  in  LEN*CHAR_LEN  packed codes; digit k = bits [k*CHAR_LEN +: CHAR_LEN].
- dots  in  LEN  decimal point per digit.
- ena  in  1  display enable.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point.
- digit_sel  out  LEN  one-hot digit strobe; bit k = digit k.
- frame_start  out  1  one-cycle pulse when a frame starts at digit 0.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; digit index 0; counters 0; snapshot 0; frame_start 0.
- Reset values, pins: seg, dp and digit_sel all inactive (all 1s when ACTIVE_LOW=1).
- States:
  - IDLE: outputs inactive. On ena=1, load the snapshot, set index 0, pulse frame_start, go to BLANK.
  - BLANK: outputs inactive for BLANK cycles, then go to SHOW.
  - SHOW: digit_sel[index] active; seg/dp driven from the snapshot for DIV-BLANK cycles.
- End of SHOW: if index < LEN-1, increment the index and go to BLANK.
- End of SHOW, wrap-around: if index = LEN-1, set index 0, reload the snapshot, pulse frame_start, go to BLANK.
- Slot counter: one counter of width clog2(DIV) counts 0..DIV-1 per slot. BLANK covers counts 0..BLANK-1; SHOW covers counts BLANK..DIV-1.
- Snapshot: numbers/dots are captured only on frame_start cycles. Input changes appear at the next frame boundary; worst-case latency is LEN*DIV+1 cycles.
- ena=0 in any non-IDLE state: go to IDLE next cycle; outputs are inactive one cycle after ena falls. There is no drain.
- ena re-asserted: always restart at digit 0 with a new snapshot.
- Decode (active-high value before polarity), codes 0–15: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Decode, codes 16–21: 16 '-'=40, 17 '_'=08, 18 'H'=76, 19 'L'=38, 20 'P'=73, 21 'r'=50.
- Decode, codes 22–63: blank (00). dp is still driven from the dot flag.
- Polarity: when ACTIVE_LOW=1, seg, dp and digit_sel are inverted at the output register.
- Reset mid-frame: outputs go inactive immediately (asynchronous).

Optional Feature:
- Macro DISPLAY_SCAN_DIM_EN.
- Defined: add input dim [2:0]. A 3-bit counter runs during SHOW, starting at 0 on entry to SHOW. digit_sel is active only when counter <= dim; seg/dp remain driven. dim is sampled at frame_start. dim=7 gives full brightness; dim=0 gives 1/8 brightness.
- Undefined: no dim port; digit_sel is active for the whole SHOW phase.

Decomposition:
- Package display_pkg holds:
  - state enum (IDLE, BLANK, SHOW);
  - character code constants (CH_DASH=16, CH_UNDER=17, CH_H=18, CH_L=19, CH_P=20, CH_R=21);
  - the 7-bit segment pattern constants.
- Sub-module display_char_decoder: purely combinational, CHAR_LEN code in, 7-bit active-high segments out. One instance, fed by the snapshot at the current index.

Test Plan:
All scenarios use DIV=16, BLANK=4, ACTIVE_LOW=1.
1. Assert reset with ena=1 -> during reset digit_sel=4'b1111, seg=7'h7F, dp=1, frame_start=0.
2. Release reset; ena=1, numbers={3,2,1,0}, dots=4'b0001 -> frame_start pulse, then 4 blank cycles.
   - Next 12 cycles: digit_sel=4'b1110, seg=7'h40, dp=0.
   - Then 4 blank cycles, then digit_sel=4'b1101, seg=7'h79, dp=1.
   - Period per frame = 64 cycles.
3. Mid-frame, change digit 0 code to 8 -> digit 0 still shows 7'h40 in the current frame; shows 7'h00 after the next frame_start.
4. Drop ena during SHOW of digit 2 -> next cycle all outputs inactive. Re-raise ena -> frame_start, then digit 0 after 4 blank cycles.
5. Code 63 with dot=1 on digit 1 -> seg=7'h7F (blank), dp=0 during digit 1 SHOW.
6. With DISPLAY_SCAN_DIM_EN, dim=1 -> within each 12-cycle SHOW, digit_sel is active on SHOW cycles 0,1,8,9 and inactive otherwise.
